// File: rtl/sync_pulse_gen.sv
// sync_pulse_gen: per-channel synchroniser, selectable edge detect, fixed-length pulse then re-arm holdoff.
// y rises SYNC_STAGES edges after capture, no backpressure; define SYNC_PULSE_OVR_EN for sticky overrun flags.
module sync_pulse_gen #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int PULSE_LEN   = 1,
  parameter int HOLDOFF     = 0
) (
  input  logic                clk1,
  input  logic                rstb,
  input  logic [CHANNELS-1:0] x,
  input  logic [1:0]          mode,
  input  logic                clr_ovr,
  output logic [CHANNELS-1:0] y,
  output logic [CHANNELS-1:0] ovr
);

  typedef enum logic [1:0] {IDLE, PULSE, HOLD} state_t;

  localparam logic [7:0] PULSE_LOAD = 8'(PULSE_LEN - 1);
  localparam logic [7:0] HOLD_LOAD  = (HOLDOFF > 0) ? 8'(HOLDOFF - 1) : 8'd0;

`ifndef SYNC_PULSE_OVR_EN
  logic unused_clr;
  assign unused_clr = clr_ovr;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync;
    logic                   s, s_d, rise, fall, hit, drop;
    state_t                 state, state_nxt;
    logic [7:0]             cnt, cnt_nxt;

    always_ff @(posedge clk1) begin
      if (rstb) begin
        sync <= '0;
        s_d  <= 1'b0;
      end else begin
        sync <= SYNC_STAGES'({sync, x[i]});
        s_d  <= s;
      end
    end

    assign s    = sync[SYNC_STAGES-1];
    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

    always_comb begin
      case (mode)
        2'b00:   hit = rise;
        2'b01:   hit = fall;
        2'b10:   hit = rise | fall;
        default: hit = 1'b0;
      endcase
    end

    always_ff @(posedge clk1) begin
      if (rstb) begin
        state <= IDLE;
        cnt   <= 8'd0;
      end else begin
        state <= state_nxt;
        cnt   <= cnt_nxt;
      end
    end

    // Any hit outside IDLE is lost; it is reported as an overrun, never queued.
    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      drop      = 1'b0;
      case (state)
        IDLE: begin
          if (hit) begin
            state_nxt = PULSE;
            cnt_nxt   = PULSE_LOAD;
          end
        end
        PULSE: begin
          drop = hit;
          if (cnt == 8'd0) begin
            if (HOLDOFF > 0) begin
              state_nxt = HOLD;
              cnt_nxt   = HOLD_LOAD;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            cnt_nxt = cnt - 8'd1;
          end
        end
        HOLD: begin
          drop = hit;
          if (cnt == 8'd0) state_nxt = IDLE;
          else             cnt_nxt   = cnt - 8'd1;
        end
        default: state_nxt = IDLE;
      endcase
    end

    assign y[i] = (state == PULSE);

`ifdef SYNC_PULSE_OVR_EN
    logic ovr_q;
    always_ff @(posedge clk1) begin
      if (rstb)         ovr_q <= 1'b0;
      else if (drop)    ovr_q <= 1'b1;
      else if (clr_ovr) ovr_q <= 1'b0;
    end
    assign ovr[i] = ovr_q;
`else
    logic unused_drop;
    assign unused_drop = drop;
    assign ovr[i]      = 1'b0;
`endif
  end

endmodule

// File: tb/tb_sync_pulse_gen.sv
// Directed bench for sync_pulse_gen: four instances with different pulse/holdoff settings share one stimulus.
module tb_sync_pulse_gen;

`ifdef SYNC_PULSE_OVR_EN
  localparam logic OVR_ON = 1'b1;
`else
  localparam logic OVR_ON = 1'b0;
`endif

  logic       clk1, rstb, clr_ovr;
  logic [3:0] x;
  logic [1:0] mode;
  logic [3:0] ya, yb, yc, yd, oa, ob, oc, od;

  sync_pulse_gen #(.CHANNELS(4), .SYNC_STAGES(2), .PULSE_LEN(3), .HOLDOFF(0)) u_a (
    .clk1(clk1), .rstb(rstb), .x(x), .mode(mode), .clr_ovr(clr_ovr), .y(ya), .ovr(oa));
  sync_pulse_gen #(.CHANNELS(4), .SYNC_STAGES(2), .PULSE_LEN(1), .HOLDOFF(0)) u_b (
    .clk1(clk1), .rstb(rstb), .x(x), .mode(mode), .clr_ovr(clr_ovr), .y(yb), .ovr(ob));
  sync_pulse_gen #(.CHANNELS(4), .SYNC_STAGES(2), .PULSE_LEN(2), .HOLDOFF(4)) u_c (
    .clk1(clk1), .rstb(rstb), .x(x), .mode(mode), .clr_ovr(clr_ovr), .y(yc), .ovr(oc));
  sync_pulse_gen #(.CHANNELS(4), .SYNC_STAGES(2), .PULSE_LEN(8), .HOLDOFF(0)) u_d (
    .clk1(clk1), .rstb(rstb), .x(x), .mode(mode), .clr_ovr(clr_ovr), .y(yd), .ovr(od));

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [3:0] x;
    logic [1:0] mode;
    logic [3:0] ea;
    logic [3:0] eb;
  } vec_t;

  vec_t vt [32];

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic do_reset();
    rstb    = 1'b1;
    x       = 4'h0;
    mode    = 2'b00;
    clr_ovr = 1'b0;
    tick();
    tick();
    rstb = 1'b0;
  endtask

  initial begin
    // Expected y is the state after the edge that follows applying the record's inputs.
    vt[0]  = '{4'h0, 2'b00, 4'h0, 4'h0}; vt[1]  = '{4'h1, 2'b00, 4'h0, 4'h0};
    vt[2]  = '{4'h1, 2'b00, 4'h0, 4'h0}; vt[3]  = '{4'h1, 2'b00, 4'h1, 4'h1};
    vt[4]  = '{4'h1, 2'b00, 4'h1, 4'h0}; vt[5]  = '{4'h1, 2'b00, 4'h1, 4'h0};
    vt[6]  = '{4'h1, 2'b00, 4'h0, 4'h0}; vt[7]  = '{4'h3, 2'b10, 4'h0, 4'h0};
    vt[8]  = '{4'h3, 2'b10, 4'h0, 4'h0}; vt[9]  = '{4'h3, 2'b10, 4'h2, 4'h2};
    vt[10] = '{4'h3, 2'b10, 4'h2, 4'h0}; vt[11] = '{4'h3, 2'b10, 4'h2, 4'h0};
    vt[12] = '{4'h3, 2'b10, 4'h0, 4'h0}; vt[13] = '{4'h1, 2'b10, 4'h0, 4'h0};
    vt[14] = '{4'h1, 2'b10, 4'h0, 4'h0}; vt[15] = '{4'h1, 2'b10, 4'h2, 4'h2};
    vt[16] = '{4'h1, 2'b10, 4'h2, 4'h0}; vt[17] = '{4'h1, 2'b10, 4'h2, 4'h0};
    vt[18] = '{4'h1, 2'b10, 4'h0, 4'h0}; vt[19] = '{4'h1, 2'b01, 4'h0, 4'h0};
    vt[20] = '{4'h3, 2'b01, 4'h0, 4'h0}; vt[21] = '{4'h3, 2'b01, 4'h0, 4'h0};
    vt[22] = '{4'h3, 2'b01, 4'h0, 4'h0}; vt[23] = '{4'h3, 2'b01, 4'h0, 4'h0};
    vt[24] = '{4'h3, 2'b01, 4'h0, 4'h0}; vt[25] = '{4'h3, 2'b01, 4'h0, 4'h0};
    vt[26] = '{4'h1, 2'b01, 4'h0, 4'h0}; vt[27] = '{4'h1, 2'b01, 4'h0, 4'h0};
    vt[28] = '{4'h1, 2'b01, 4'h2, 4'h2}; vt[29] = '{4'h1, 2'b01, 4'h2, 4'h0};
    vt[30] = '{4'h1, 2'b01, 4'h2, 4'h0}; vt[31] = '{4'h1, 2'b01, 4'h0, 4'h0};

    // Held in reset with all inputs high: nothing may fire.
    rstb = 1'b1; x = 4'hF; mode = 2'b00; clr_ovr = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rst_y", ya | yb | yc | yd, 4'h0);
      chk("rst_ovr", oa | ob | oc | od, 4'h0);
    end
    rstb = 1'b0;
    for (int k = 0; k < 9; k++) begin
      tick();
      chk($sformatf("rel_y%0d", k), ya, (k >= 2 && k <= 4) ? 4'hF : 4'h0);
    end

    // Latency/length and edge-mode vectors.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      x    = vt[i].x;
      mode = vt[i].mode;
      tick();
      chk($sformatf("vec%0d_a", i), ya, vt[i].ea);
      chk($sformatf("vec%0d_b", i), yb, vt[i].eb);
    end

    // Second rise on ch2 lands in C's holdoff and on A's final pulse cycle.
    do_reset();
    tick();
    tick();
    for (int k = 0; k < 13; k++) begin
      x = (k == 0 || k >= 3) ? 4'h4 : 4'h0;
      tick();
      chk($sformatf("ho_yc%0d", k), yc, (k == 2 || k == 3) ? 4'h4 : 4'h0);
      chk($sformatf("ho_ya%0d", k), ya, (k >= 2 && k <= 4) ? 4'h4 : 4'h0);
      chk($sformatf("ho_ovc%0d", k), oc, (k >= 5) ? {1'b0, OVR_ON, 2'b00} : 4'h0);
      chk($sformatf("ho_ova%0d", k), oa, (k >= 5) ? {1'b0, OVR_ON, 2'b00} : 4'h0);
    end
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    chk("clr_ovc", oc, 4'h0);
    chk("clr_ova", oa, 4'h0);

    // Reset during the third cycle of an 8-cycle pulse, x low and stable afterwards.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      x    = (k <= 1) ? 4'h1 : 4'h0;
      rstb = (k == 5 || k == 6);
      tick();
      chk($sformatf("mid_yd%0d", k), yd, (k >= 2 && k <= 4) ? 4'h1 : 4'h0);
    end
    rstb = 1'b0;

    // Disable mid-pulse: the pulse completes, later edges are ignored.
    do_reset();
    for (int k = 0; k < 18; k++) begin
      x    = (k >= 8 && k <= 10) ? 4'h0 : 4'h8;
      mode = (k >= 3) ? 2'b11 : 2'b00;
      tick();
      chk($sformatf("dis_ya%0d", k), ya, (k >= 2 && k <= 4) ? 4'h8 : 4'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sync_pulse_gen.md
# sync_pulse_gen

Multi-channel edge-to-pulse synchroniser: the parametrised successor of the single-channel level-to-one-cycle-pulse converter used at the ADC unit clock-domain boundaries. Each channel synchronises a slow or asynchronous input into `clk1`, detects a selectable edge, and emits a pulse of programmable length followed by a programmable re-arm holdoff. It sits between slow control/trigger sources and the ADC unit's fast-clock logic, one instance per group of related strobes.

## Interface
Parameters:
- `CHANNELS`, 4: number of independent channels, 1..32.
- `SYNC_STAGES`, 2: input synchroniser flip-flops per channel, 1..4.
- `PULSE_LEN`, 1: output pulse length in `clk1` cycles, 1..255.
- `HOLDOFF`, 0: dead cycles after each pulse before the channel re-arms, 0..255.

Ports:
- `clk1` input 1: the single clock; all logic on its rising edge.
- `rstb` input 1: reset, synchronous and active-high.
- `x` input CHANNELS: per-channel level inputs, any domain.
- `mode` input 2: edge select for all channels: 00 rise, 01 fall, 10 both, 11 disabled.
- `clr_ovr` input 1: clears all overrun flags (macro-dependent).
- `y` output CHANNELS: per-channel registered pulse outputs.
- `ovr` output CHANNELS: sticky per-channel overrun flags (macro-dependent).

## Operation
- Per channel: shift chain `sync[SYNC_STAGES-1:0]` from `x[i]`, then `s_d` holds the previous last-stage value.
- Edge terms: `rise = s & ~s_d`, `fall = ~s & s_d`; `hit` = rise, fall, rise|fall or 0 per `mode`.
- Per-channel FSM, states IDLE, PULSE, HOLD; counter `cnt`, 8 bits, unsigned, no wrap (saturates at loads only).
  - IDLE: `y`=0. On `hit`: go PULSE, `cnt` <= PULSE_LEN-1.
  - PULSE: `y`=1. If `cnt`==0: go HOLD with `cnt` <= HOLDOFF-1 when HOLDOFF>0, else go IDLE; otherwise `cnt` decrements.
  - HOLD: `y`=0. If `cnt`==0 go IDLE, else decrement.
  - With HOLDOFF=0, HOLD is unreachable; a `hit` on the final PULSE cycle is dropped (overrun), not chained.
- `hit` in PULSE or HOLD is discarded; pulses never merge or extend.
- `y` is decoded from registered state only: glitch-free, no combinational path from `x`.
- `mode` is sampled every cycle, not latched; a change does not abort a pulse in progress. Mode 11 lets running pulses/holdoffs finish, then no new pulses.
- Channels are fully independent; no shared counters.
- Reset: all `sync`, `s_d` = 0; state IDLE; `cnt` = 0; `y` = 0; `ovr` = 0. Reset mid-pulse drops `y` on the next edge. If `x[i]` is high out of reset, rise mode (and both) produces one pulse once the 0→1 propagates; fall mode does not.

## Timing
- Latency: `x[i]` change captured at edge E0 gives `hit` after edge E0+SYNC_STAGES-1; `y[i]` rises after edge E0+SYNC_STAGES and stays high exactly PULSE_LEN cycles.
- Minimum spacing between two pulse starts on one channel: PULSE_LEN+HOLDOFF+1 cycles (an extra cycle for IDLE to see `hit`).
- Input level must be stable at the sync stage output for ≥1 cycle for an edge to register; shorter excursions may be lost.
- `ovr[i]` sets the cycle after a discarded `hit`; `clr_ovr` takes effect next edge; simultaneous discard and `clr_ovr`: set wins.

## Configuration
- `SYNC_PULSE_OVR_EN` defined: overrun logic present as above.
- Not defined: `ovr` tied to 0, `clr_ovr` ignored, no overrun registers synthesised; all other behaviour identical.

## Test plan
- Reset/idle: CHANNELS=4, hold `rstb`=1 5 cycles with `x`=4'hF -> `y`=0, `ovr`=0 throughout; release with mode 00 -> each `y[i]` single pulse starting SYNC_STAGES cycles after release.
- Latency/length: SYNC_STAGES=2, PULSE_LEN=3, mode 00, `x[0]` 0→1 captured at edge 10 -> `y[0]` high after edges 12,13,14, low after 15; other channels 0.
- Mode both: PULSE_LEN=1, HOLDOFF=0, `x[1]` high for 6 cycles -> exactly two one-cycle pulses, 6 cycles apart; mode 01 same stimulus -> only the second.
- Holdoff/overrun: PULSE_LEN=2, HOLDOFF=4, rise on `x[2]`, second rise 3 cycles later -> one pulse only, `ovr[2]`=1 (macro on) / 0 (macro off); `clr_ovr` pulse -> `ovr[2]`=0 next cycle.
- Reset mid-pulse: PULSE_LEN=8, assert `rstb` during cycle 3 of pulse -> `y`=0 next edge, no resumed pulse after release with `x` stable.
- Disable: mode 11 asserted mid-pulse -> current pulse completes at full length; subsequent edges produce no `y`.
